// File: rtl/osd_rect_writer.sv
// Rectangle-fill / clear-screen write engine for the 1-bit OSD frame buffer.
// Optional macro OSD_CLIP_EN clips rectangles to the visible area.
module osd_rect_writer #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 19
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iCMD_VALID,
    output logic              oCMD_READY,
    input  logic              iCMD_CLEAR,
    input  logic [9:0]        iCMD_X,
    input  logic [9:0]        iCMD_Y,
    input  logic [9:0]        iCMD_W,
    input  logic [9:0]        iCMD_H,
    input  logic              iCMD_COLOR,
    output logic              oWR_EN,
    output logic [ADDR_W-1:0] oWR_ADDR,
    output logic              oWR_DATA,
    input  logic              iWR_READY,
    output logic              oBUSY,
    output logic              oDONE
);

    typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;

    localparam logic [9:0]        H_MAX  = 10'(H_RES);
    localparam logic [9:0]        V_MAX  = 10'(V_RES);
    localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_RES);

    state_t state, next_state;

    logic              clear_q;
    logic              color_q;
    logic [9:0]        x_q, y_q, w_q, h_q;
    logic [9:0]        cols_q, rows_q;
    logic [9:0]        col, row;
    logic [ADDR_W-1:0] row_base;

    logic [9:0]        setup_cols, setup_rows;
    logic [ADDR_W-1:0] setup_base;
    logic              setup_zero;
    logic              last_col, last_row;

    always_comb begin
        setup_base = ADDR_W'(y_q) * H_STEP + ADDR_W'(x_q);
        setup_cols = w_q;
        setup_rows = h_q;
        if (clear_q) begin
            setup_base = '0;
            setup_cols = H_MAX;
            setup_rows = V_MAX;
        end else begin
`ifdef OSD_CLIP_EN
            if (x_q >= H_MAX || y_q >= V_MAX) begin
                setup_cols = '0;
                setup_rows = '0;
            end else begin
                setup_cols = (w_q < H_MAX - x_q) ? w_q : H_MAX - x_q;
                setup_rows = (h_q < V_MAX - y_q) ? h_q : V_MAX - y_q;
            end
`else
            setup_cols = w_q;
            setup_rows = h_q;
`endif
        end
        setup_zero = (setup_cols == '0) || (setup_rows == '0);
    end

    assign last_col = (col == cols_q - 10'd1);
    assign last_row = (row == rows_q - 10'd1);

    always_ff @(posedge iCLK) begin
        if (iRST)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (iCMD_VALID) next_state = SETUP;
            SETUP:   next_state = setup_zero ? DONE : DRAW;
            DRAW:    if (iWR_READY && last_col && last_row) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        oCMD_READY = (state == IDLE);
        oBUSY      = (state != IDLE);
        oDONE      = (state == DONE);
        oWR_EN     = (state == DRAW);
        oWR_ADDR   = '0;
        oWR_DATA   = 1'b0;
        if (state == DRAW) begin
            oWR_ADDR = row_base + ADDR_W'(col);
            oWR_DATA = color_q;
        end
    end

    // Row stepping adds the stride so no multiplier is needed inside DRAW.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            clear_q  <= 1'b0;
            color_q  <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            w_q      <= '0;
            h_q      <= '0;
            cols_q   <= '0;
            rows_q   <= '0;
            col      <= '0;
            row      <= '0;
            row_base <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (iCMD_VALID) begin
                        clear_q <= iCMD_CLEAR;
                        color_q <= iCMD_COLOR;
                        x_q     <= iCMD_X;
                        y_q     <= iCMD_Y;
                        w_q     <= iCMD_W;
                        h_q     <= iCMD_H;
                    end
                end
                SETUP: begin
                    row_base <= setup_base;
                    cols_q   <= setup_cols;
                    rows_q   <= setup_rows;
                    col      <= '0;
                    row      <= '0;
                end
                DRAW: begin
                    if (iWR_READY) begin
                        if (last_col) begin
                            col      <= '0;
                            row      <= row + 10'd1;
                            row_base <= row_base + H_STEP;
                        end else begin
                            col <= col + 10'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
